share_encoder: RTL and testbench

- Boolean masking encoder for first-order two-share gadgets: converts an unmasked word into shares s0 = x ^ r and s1 = r, using one fresh random word per encoding.
- Feeds masked datapaths built from two-share gadgets, such as the DOM AND.
- Has a valid/ready input, a valid/ready randomness port and a valid/ready output.
- Encoded share pairs are buffered in a small FIFO, so downstream back-pressure does not stall the randomness source mid-word.

---
 rtl/share_encoder.sv | 78 +++++++
 tb/tb_share_encoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/share_encoder.sv
// rtl/share_encoder.sv - first-order boolean masking encoder (s0 = x ^ r, s1 = r) with share-pair output FIFO
module share_encoder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    input  logic [WIDTH-1:0] rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s0,
    output logic [WIDTH-1:0] out_s1,
    output logic [15:0]      cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          full;
    logic          fire;
    logic          pop;

    // Share domains live in physically separate arrays; nothing ever merges them.
    (* share_domain = 0 *) logic [WIDTH-1:0] s0_mem [DEPTH];
    (* share_domain = 1 *) logic [WIDTH-1:0] s1_mem [DEPTH];

    assign full      = (occ == FULL_OCC);
    assign in_ready  = rst_n & rnd_valid & ~full & ~clr;
    assign rnd_ready = rst_n & in_valid & ~full & ~clr;
    assign fire      = rst_n & in_valid & rnd_valid & ~full & ~clr;
    assign out_valid = (occ != '0);
    assign pop       = out_valid & out_ready & ~clr;
    assign out_s0    = s0_mem[rd_ptr];
    assign out_s1    = s1_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                s0_mem[i] <= '0;
                s1_mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            cnt    <= '0;
        end else begin
            if (fire) begin
                s0_mem[wr_ptr] <= in_data ^ rnd;
                s1_mem[wr_ptr] <= rnd;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                cnt    <= cnt + 16'd1;
            end
            case ({fire, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_share_encoder.sv
// tb/tb_share_encoder.sv - randomized and directed bench for share_encoder against a queue model
module tb_share_encoder;
    localparam int W = 8;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic         in_valid = 1'b0;
    logic         rnd_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic [W-1:0] rnd = '0;
    logic         in_ready, rnd_ready, out_valid;
    logic [W-1:0] out_s0, out_s1;
    logic [15:0]  cnt;

    share_encoder #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s0(out_s0), .out_s1(out_s1), .cnt(cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] s0;
        logic [W-1:0] s1;
    } ent_t;

    ent_t mq[$];
    int   mcnt = 0;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: the FIFO is a plain queue of share pairs; one pop per accepted handshake.
    always @(negedge rst_n) begin
        mq.delete();
        mcnt = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            bit m_full, m_fire, m_pop;
            m_full = (mq.size() == D);
            m_fire = in_valid && rnd_valid && !m_full && !clr;
            m_pop  = (mq.size() != 0) && out_ready && !clr;
            if (clr) begin
                mq.delete();
                mcnt = 0;
            end else begin
                if (m_pop) begin
                    void'(mq.pop_front());
                    mcnt = (mcnt + 1) % 65536;
                end
                if (m_fire) mq.push_back('{x: in_data, s0: in_data ^ rnd, s1: rnd});
            end
        end
    end

    always @(negedge clk) begin
        bit m_full;
        m_full = (mq.size() == D);
        chk("in_ready", in_ready, rst_n && rnd_valid && !m_full && !clr);
        chk("rnd_ready", rnd_ready, rst_n && in_valid && !m_full && !clr);
        chk("out_valid", out_valid, mq.size() != 0);
        chk("cnt", cnt, mcnt);
        if (!rst_n) begin
            chk("rst_s0", out_s0, 0);
            chk("rst_s1", out_s1, 0);
        end else if (mq.size() != 0) begin
            chk("out_s0", out_s0, mq[0].s0);
            chk("out_s1", out_s1, mq[0].s1);
            chk("recombine", out_s0 ^ out_s1, mq[0].x);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] r);
        in_valid  = v;
        rnd_valid = v;
        in_data   = x;
        rnd       = r;
    endtask

    initial begin
        // reset state, with valids asserted to show the ready outputs stay low
        in_valid  = 1'b1;
        rnd_valid = 1'b1;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rnd_ready", rnd_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        drive(1'b0, 8'h00, 8'h00);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // single word
        out_ready = 1'b1;
        drive(1'b1, 8'hA5, 8'h3C);
        cyc();
        drive(1'b0, 8'h00, 8'h00);
        chk("single_valid", out_valid, 1);
        chk("single_s0", out_s0, 8'h99);
        chk("single_s1", out_s1, 8'h3C);
        cyc();
        chk("single_cnt", cnt, 1);
        chk("single_empty", out_valid, 0);

        // randomness starvation
        in_valid = 1'b1;
        in_data  = 8'h12;
        for (int i = 0; i < 5; i++) begin
            chk("starve_in_ready", in_ready, 0);
            cyc();
            chk("starve_no_push", out_valid, 0);
        end
        rnd_valid = 1'b1;
        rnd       = 8'hFF;
        #1;
        chk("starve_in_ready_up", in_ready, 1);
        cyc();
        drive(1'b0, 8'h00, 8'h00);
        chk("starve_s0", out_s0, 8'hED);
        chk("starve_s1", out_s1, 8'hFF);
        cyc();
        chk("starve_one_entry", out_valid, 0);

        // clr mid-operation with a concurrent push and pop request
        out_ready = 1'b0;
        drive(1'b1, 8'h44, 8'h55);
        cyc();
        cyc();
        clr       = 1'b1;
        out_ready = 1'b1;
        cyc();
        clr = 1'b0;
        drive(1'b0, 8'h00, 8'h00);
        chk("clr_empty", out_valid, 0);
        chk("clr_cnt", cnt, 0);

        // back-pressure and full-with-simultaneous-pop
        out_ready = 1'b0;
        drive(1'b1, 8'h01, 8'h10);
        cyc();
        drive(1'b1, 8'h02, 8'h20);
        cyc();
        drive(1'b1, 8'h03, 8'h30);
        #1;
        chk("bp_in_ready_full", in_ready, 0);
        chk("bp_rnd_ready_full", rnd_ready, 0);
        chk("bp_head_s0", out_s0, 8'h11);
        chk("bp_head_s1", out_s1, 8'h10);
        out_ready = 1'b1;
        cyc();
        chk("bp_pop_only_s0", out_s0, 8'h22);
        chk("bp_pop_only_s1", out_s1, 8'h20);
        chk("bp_in_ready_after", in_ready, 1);
        cyc();
        drive(1'b0, 8'h00, 8'h00);
        chk("bp_third_s0", out_s0, 8'h33);
        chk("bp_third_s1", out_s1, 8'h30);
        cyc();
        chk("bp_drained", out_valid, 0);
        chk("bp_cnt", cnt, 3);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            rnd_valid = ($urandom_range(3) != 0);
            out_ready = $urandom_range(1);
            clr       = ($urandom_range(49) == 0);
            in_data   = W'($urandom);
            rnd       = W'($urandom);
            cyc();
        end
        clr = 1'b0;

        // streaming through a counter wrap
        clr = 1'b1;
        cyc();
        clr       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            drive(1'b1, W'($urandom), W'($urandom));
            cyc();
        end
        drive(1'b0, 8'h00, 8'h00);
        cyc();
        chk("stream_cnt_wrap", cnt, 16'd4464);

        // asynchronous reset between edges with entries buffered
        out_ready = 1'b0;
        drive(1'b1, 8'h5A, 8'hC3);
        cyc();
        cyc();
        drive(1'b0, 8'h00, 8'h00);
        chk("pre_rst_full", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_cnt", cnt, 0);
        chk("async_rst_s0", out_s0, 0);
        #1;
        rst_n = 1'b1;
        cyc();
        chk("post_rst_empty", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
